// File: rtl/regfile_scb.sv
// regfile_scb: parametrised register file with load scoreboard, same-cycle write bypass
// and a multi-mode PC register living at the top register index.
module regfile_scb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int PC_W     = 11,
    parameter int NUM_RD   = 4,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_en1,
    input  logic [AW-1:0]            w_addr1,
    input  logic [DATA_W-1:0]        w_data1,
    input  logic                     w_en_ldr,
    input  logic [AW-1:0]            w_addr_ldr,
    input  logic [DATA_W-1:0]        w_data_ldr,
    input  logic                     ldr_issue,
    input  logic [AW-1:0]            ldr_issue_addr,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic                     ldr_err,
    input  logic                     load_pc,
    input  logic [1:0]               sel_pc,
    input  logic [PC_W-1:0]          start_pc,
    input  logic [PC_W-1:0]          dp_pc,
    output logic [PC_W-1:0]          pc_out
);
    localparam logic [AW-1:0] PC_IDX = AW'(NUM_REGS - 1);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                ldr_err_q, ldr_err_d;
    logic [PC_W-1:0]     pc_q, pc_d;

    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < NUM_REGS - 1; r++) begin
            if (w_en1 && w_addr1 == AW'(r)) regs_d[r] = w_data1;
            if (w_en_ldr && w_addr_ldr == AW'(r)) regs_d[r] = w_data_ldr;
        end
        regs_d[NUM_REGS-1] = '0;
        busy_d = busy_q;
        if (w_en_ldr) busy_d[w_addr_ldr] = 1'b0;
        // issue after return so a same-cycle reissue keeps the register busy
        if (ldr_issue && ldr_issue_addr != PC_IDX) busy_d[ldr_issue_addr] = 1'b1;
        busy_d[NUM_REGS-1] = 1'b0;
        ldr_err_d = ldr_issue && (ldr_issue_addr == PC_IDX ||
                    (busy_q[ldr_issue_addr] && !(w_en_ldr && w_addr_ldr == ldr_issue_addr)));
        pc_d = !load_pc          ? pc_q     :
               sel_pc == 2'b01   ? start_pc :
               sel_pc == 2'b11   ? dp_pc    : pc_q + PC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q    <= '{default: '0};
            busy_q    <= '0;
            ldr_err_q <= 1'b0;
            pc_q      <= '0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            ldr_err_q <= ldr_err_d;
            pc_q      <= pc_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] stored;
        logic              hit_ldr, hit_w1;
        always_comb begin
            a       = rd_addr[i*AW +: AW];
            stored  = a == PC_IDX ? DATA_W'(pc_q) : regs_q[a];
            hit_ldr = BYPASS != 0 && a != PC_IDX && w_en_ldr && w_addr_ldr == a;
            hit_w1  = BYPASS != 0 && a != PC_IDX && w_en1 && w_addr1 == a;
            rd_data[i*DATA_W +: DATA_W] = hit_ldr ? w_data_ldr : hit_w1 ? w_data1 : stored;
            rd_busy[i] = busy_q[a];
        end
    end

    assign busy_vec = busy_q;
    assign ldr_err  = ldr_err_q;
    assign pc_out   = pc_q;
endmodule

// File: tb/tb_regfile_scb.sv
// tb_regfile_scb: directed vector table for the default and no-bypass files,
// plus hand sequences for async reset and a 32x64, 6-port instance.
module tb_regfile_scb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         w_en1, w_en_ldr, ldr_issue, load_pc;
    logic [3:0]   w_addr1, w_addr_ldr, ldr_issue_addr;
    logic [31:0]  w_data1, w_data_ldr;
    logic [15:0]  rd_addr;
    logic [1:0]   sel_pc;
    logic [10:0]  start_pc, dp_pc;
    logic [127:0] rd_data, nb_rd_data;
    logic [3:0]   rd_busy, nb_rd_busy;
    logic [15:0]  busy_vec, nb_busy_vec;
    logic         ldr_err, nb_ldr_err;
    logic [10:0]  pc_out, nb_pc_out;

    logic         b_w1, b_wl, b_zero;
    logic [4:0]   b_a1, b_al, b_za;
    logic [63:0]  b_d1, b_dl;
    logic [29:0]  b_ra;
    logic [1:0]   b_zs;
    logic [10:0]  b_zpc;
    logic [383:0] b_rd;
    logic [5:0]   b_rb;
    logic [31:0]  b_bv;
    logic         b_err;
    logic [10:0]  b_pc;

    regfile_scb dut (
        .clk(clk), .rst_n(rst_n),
        .w_en1(w_en1), .w_addr1(w_addr1), .w_data1(w_data1),
        .w_en_ldr(w_en_ldr), .w_addr_ldr(w_addr_ldr), .w_data_ldr(w_data_ldr),
        .ldr_issue(ldr_issue), .ldr_issue_addr(ldr_issue_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .busy_vec(busy_vec), .ldr_err(ldr_err),
        .load_pc(load_pc), .sel_pc(sel_pc), .start_pc(start_pc), .dp_pc(dp_pc),
        .pc_out(pc_out)
    );

    regfile_scb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .w_en1(w_en1), .w_addr1(w_addr1), .w_data1(w_data1),
        .w_en_ldr(w_en_ldr), .w_addr_ldr(w_addr_ldr), .w_data_ldr(w_data_ldr),
        .ldr_issue(ldr_issue), .ldr_issue_addr(ldr_issue_addr),
        .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .busy_vec(nb_busy_vec), .ldr_err(nb_ldr_err),
        .load_pc(load_pc), .sel_pc(sel_pc), .start_pc(start_pc), .dp_pc(dp_pc),
        .pc_out(nb_pc_out)
    );

    regfile_scb #(.NUM_REGS(32), .DATA_W(64), .NUM_RD(6)) dut_big (
        .clk(clk), .rst_n(rst_n),
        .w_en1(b_w1), .w_addr1(b_a1), .w_data1(b_d1),
        .w_en_ldr(b_wl), .w_addr_ldr(b_al), .w_data_ldr(b_dl),
        .ldr_issue(b_zero), .ldr_issue_addr(b_za),
        .rd_addr(b_ra), .rd_data(b_rd), .rd_busy(b_rb),
        .busy_vec(b_bv), .ldr_err(b_err),
        .load_pc(b_zero), .sel_pc(b_zs), .start_pc(b_zpc), .dp_pc(b_zpc),
        .pc_out(b_pc)
    );

    typedef struct {
        logic w1; logic [3:0] a1; logic [31:0] d1;
        logic wl; logic [3:0] al; logic [31:0] dl;
        logic li; logic [3:0] lia; logic [15:0] ra;
        logic lp; logic [1:0] sp; logic [10:0] pcv;
        logic [31:0] rd0, rd1, nb0; logic [3:0] rb; logic [15:0] bv; logic err; logic [10:0] pc;
    } vec_t;

    vec_t vecs [22];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        {w_en1, w_en_ldr, ldr_issue, load_pc} = '0;
        {w_addr1, w_addr_ldr, ldr_issue_addr, sel_pc} = '0;
        {w_data1, w_data_ldr, start_pc, dp_pc} = '0;
    endtask

    logic [63:0] bexp [6];

    initial begin
        // inputs: w1,a1,d1 | wl,al,dl | li,lia,ra | lp,sp,pcv || rd0,rd1,nb0,rb,bv,err,pc (pre-edge)
        vecs[0]  = '{1'b1,4'h3,32'hAAAAAAAA, 1'b1,4'h3,32'h55555555, 1'b0,4'h0,16'hF543, 1'b0,2'b00,11'h0,
                     32'h55555555,32'h0,32'h0,4'h0,16'h0,1'b0,11'h0};
        vecs[1]  = '{1'b1,4'h4,32'h11111111, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF543, 1'b0,2'b00,11'h0,
                     32'h55555555,32'h11111111,32'h55555555,4'h0,16'h0,1'b0,11'h0};
        vecs[2]  = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b1,4'h5,16'hF543, 1'b0,2'b00,11'h0,
                     32'h55555555,32'h11111111,32'h55555555,4'h0,16'h0,1'b0,11'h0};
        vecs[3]  = '{1'b0,4'h0,32'h0, 1'b1,4'h5,32'h99, 1'b1,4'h5,16'hF543, 1'b0,2'b00,11'h0,
                     32'h55555555,32'h11111111,32'h55555555,4'h4,16'h0020,1'b0,11'h0};
        vecs[4]  = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b1,4'h5,16'hF543, 1'b0,2'b00,11'h0,
                     32'h55555555,32'h11111111,32'h55555555,4'h4,16'h0020,1'b0,11'h0};
        vecs[5]  = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF543, 1'b0,2'b00,11'h0,
                     32'h55555555,32'h11111111,32'h55555555,4'h4,16'h0020,1'b1,11'h0};
        vecs[6]  = '{1'b0,4'h0,32'h0, 1'b1,4'h5,32'h42, 1'b0,4'h0,16'hF545, 1'b0,2'b00,11'h0,
                     32'h42,32'h11111111,32'h99,4'h5,16'h0020,1'b0,11'h0};
        vecs[7]  = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF545, 1'b0,2'b00,11'h0,
                     32'h42,32'h11111111,32'h42,4'h0,16'h0,1'b0,11'h0};
        vecs[8]  = '{1'b1,4'hF,32'hFFFFFFFF, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF55F, 1'b1,2'b01,11'h010,
                     32'h0,32'h42,32'h0,4'h0,16'h0,1'b0,11'h0};
        vecs[9]  = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF55F, 1'b1,2'b00,11'h0,
                     32'h10,32'h42,32'h10,4'h0,16'h0,1'b0,11'h010};
        vecs[10] = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF55F, 1'b1,2'b00,11'h0,
                     32'h11,32'h42,32'h11,4'h0,16'h0,1'b0,11'h011};
        vecs[11] = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF55F, 1'b1,2'b00,11'h0,
                     32'h12,32'h42,32'h12,4'h0,16'h0,1'b0,11'h012};
        vecs[12] = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF55F, 1'b1,2'b11,11'h7FF,
                     32'h13,32'h42,32'h13,4'h0,16'h0,1'b0,11'h013};
        vecs[13] = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF55F, 1'b1,2'b10,11'h0,
                     32'h7FF,32'h42,32'h7FF,4'h0,16'h0,1'b0,11'h7FF};
        vecs[14] = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF55F, 1'b0,2'b01,11'h123,
                     32'h0,32'h42,32'h0,4'h0,16'h0,1'b0,11'h0};
        vecs[15] = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b1,4'hF,16'hF55F, 1'b0,2'b00,11'h0,
                     32'h0,32'h42,32'h0,4'h0,16'h0,1'b0,11'h0};
        vecs[16] = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF55F, 1'b0,2'b00,11'h0,
                     32'h0,32'h42,32'h0,4'h0,16'h0,1'b1,11'h0};
        vecs[17] = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b1,4'h2,16'hF542, 1'b0,2'b00,11'h0,
                     32'h0,32'h11111111,32'h0,4'h0,16'h0,1'b0,11'h0};
        vecs[18] = '{1'b1,4'h2,32'hDEADBEEF, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF542, 1'b0,2'b00,11'h0,
                     32'hDEADBEEF,32'h11111111,32'h0,4'h1,16'h0004,1'b0,11'h0};
        vecs[19] = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b1,4'h4,16'hF542, 1'b0,2'b00,11'h0,
                     32'hDEADBEEF,32'h11111111,32'hDEADBEEF,4'h1,16'h0004,1'b0,11'h0};
        vecs[20] = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF542, 1'b1,2'b01,11'h123,
                     32'hDEADBEEF,32'h11111111,32'hDEADBEEF,4'h3,16'h0014,1'b0,11'h0};
        vecs[21] = '{1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 1'b0,4'h0,16'hF542, 1'b0,2'b00,11'h0,
                     32'hDEADBEEF,32'h11111111,32'hDEADBEEF,4'h3,16'h0014,1'b0,11'h123};

        idle();
        rd_addr = 16'hF543;
        {b_w1, b_wl, b_zero, b_a1, b_al, b_za, b_d1, b_dl, b_zs, b_zpc} = '0;
        b_ra = '0;
        #2;
        chk("reset busy_vec", 64'(busy_vec), 64'h0);
        chk("reset pc_out", 64'(pc_out), 64'h0);
        chk("reset ldr_err", 64'(ldr_err), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            {w_en1, w_addr1, w_data1} = {vecs[i].w1, vecs[i].a1, vecs[i].d1};
            {w_en_ldr, w_addr_ldr, w_data_ldr} = {vecs[i].wl, vecs[i].al, vecs[i].dl};
            {ldr_issue, ldr_issue_addr, rd_addr} = {vecs[i].li, vecs[i].lia, vecs[i].ra};
            {load_pc, sel_pc, start_pc, dp_pc} = {vecs[i].lp, vecs[i].sp, vecs[i].pcv, vecs[i].pcv};
            #1;
            chk($sformatf("v%0d rd0", i), 64'(rd_data[31:0]), 64'(vecs[i].rd0));
            chk($sformatf("v%0d rd1", i), 64'(rd_data[63:32]), 64'(vecs[i].rd1));
            chk($sformatf("v%0d nobypass rd0", i), 64'(nb_rd_data[31:0]), 64'(vecs[i].nb0));
            chk($sformatf("v%0d rd_busy", i), 64'(rd_busy), 64'(vecs[i].rb));
            chk($sformatf("v%0d busy_vec", i), 64'(busy_vec), 64'(vecs[i].bv));
            chk($sformatf("v%0d nobypass busy_vec", i), 64'(nb_busy_vec), 64'(vecs[i].bv));
            chk($sformatf("v%0d ldr_err", i), 64'(ldr_err), 64'(vecs[i].err));
            chk($sformatf("v%0d pc_out", i), 64'(pc_out), 64'(vecs[i].pc));
            chk($sformatf("v%0d nobypass pc_out", i), 64'(nb_pc_out), 64'(vecs[i].pc));
        end

        // asynchronous reset mid-cycle with busy_vec=0x14, PC=0x123
        @(negedge clk);
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async busy_vec", 64'(busy_vec), 64'h0);
        chk("async pc_out", 64'(pc_out), 64'h0);
        chk("async rd_data lo", rd_data[63:0], 64'h0);
        chk("async rd_data hi", rd_data[127:64], 64'h0);
        chk("async rd_busy", 64'(rd_busy), 64'h0);
        chk("async nobypass rd_data", nb_rd_data[63:0], 64'h0);
        chk("async nobypass ldr_err", 64'(nb_ldr_err), 64'h0);
        chk("async nobypass rd_busy", 64'(nb_rd_busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        {w_en_ldr, w_addr_ldr, w_data_ldr} = {1'b1, 4'h4, 32'h77};
        rd_addr = 16'hF544;
        #1;
        chk("post-reset ldr bypass", 64'(rd_data[31:0]), 64'h77);
        chk("post-reset busy_vec", 64'(busy_vec), 64'h0);
        @(negedge clk);
        idle();
        #1;
        chk("post-reset ldr stored", 64'(rd_data[31:0]), 64'h77);
        chk("post-reset busy after return", 64'(busy_vec), 64'h0);

        // 32x64, six ports: PC at index 31
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            {b_w1, b_a1, b_d1} = {1'b1, 5'(k), 32'hC0DE0000, 32'(k)};
        end
        @(negedge clk);
        {b_w1, b_a1, b_d1} = {1'b1, 5'd7, 64'hA7A7_0000_0000_00A7};
        {b_wl, b_al, b_dl} = {1'b1, 5'd8, 64'hB8B8_0000_0000_00B8};
        b_ra = {5'd31, 5'd8, 5'd7, 5'd3, 5'd2, 5'd1};
        bexp = '{64'hC0DE0000_00000001, 64'hC0DE0000_00000002, 64'hC0DE0000_00000003,
                 64'hA7A7_0000_0000_00A7, 64'hB8B8_0000_0000_00B8, 64'h0};
        #1;
        for (int p = 0; p < 6; p++)
            chk($sformatf("big bypass port%0d", p), b_rd[p*64 +: 64], bexp[p]);
        @(negedge clk);
        b_w1 = 1'b0;
        {b_wl, b_al, b_dl} = {1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};
        b_ra = {5'd31, 5'd8, 5'd7, 5'd3, 5'd2, 5'd1};
        #1;
        for (int p = 0; p < 6; p++)
            chk($sformatf("big stored port%0d", p), b_rd[p*64 +: 64], bexp[p]);
        @(negedge clk);
        b_wl = 1'b0;
        #1;
        chk("big pc protected", 64'(b_pc), 64'h0);
        chk("big busy_vec", 64'(b_bv), 64'h0);
        chk("big rd_busy", 64'(b_rb), 64'h0);
        chk("big ldr_err", 64'(b_err), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_scb.md
# regfile_scb

Parametrised architectural register file for the ARM32 datapath with an integrated load scoreboard, same-cycle write-to-read bypass and a multi-mode PC register. It replaces the fixed 16x32 file: register count, data width, PC width and read-port count are parameters. It adds per-register busy tracking for outstanding LDRs so the controller can stall on hazards. Sits between the decode/controller stage (addresses, PC control) and the ALU/shifter/store paths.

## Interface
- DATA_W, 32, register data width
- NUM_REGS, 16, register count including PC; PC is index NUM_REGS-1; AW = $clog2(NUM_REGS)
- PC_W, 11, PC width (instruction-word address)
- NUM_RD, 4, combinational read ports (A, B, shift, str in the current core)
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = read stored value only

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- w_en1 / w_addr1 / w_data1  in  1/AW/DATA_W  ALU write port
- w_en_ldr / w_addr_ldr / w_data_ldr  in  1/AW/DATA_W  load-return write port; also clears busy
- ldr_issue / ldr_issue_addr  in  1/AW  LDR issued, mark destination busy
- rd_addr  in  NUM_RD*AW  packed read addresses, port i at [i*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  packed read data
- rd_busy  out  NUM_RD  port i's register has an outstanding load
- busy_vec  out  NUM_REGS  scoreboard state
- ldr_err  out  1  registered one-cycle pulse: issue to an already-busy register
- load_pc / sel_pc  in  1/2  PC update enable and source select
- start_pc / dp_pc  in  PC_W/PC_W  PC sources
- pc_out  out  PC_W  current PC

## Operation
- Storage: NUM_REGS-1 general registers of DATA_W plus PC register of PC_W. Writes to index NUM_REGS-1 from either write port are ignored.
- Reads: rd_data[i] = register[rd_addr[i]]. Address NUM_REGS-1 returns pc_out zero-extended to DATA_W.
- Bypass (BYPASS=1): for a non-PC address, if w_en_ldr hits rd_addr[i], the port returns w_data_ldr. Else if w_en1 hits it, the port returns w_data1. Else it returns the stored value.
- Dual write, same address, same cycle: the ldr port wins, both stored and bypassed.
- Scoreboard: busy[r] sets on ldr_issue with addr r and clears on w_en_ldr with addr r.
  - Issue and return to the same r in the same cycle: busy stays 1 (new load outstanding).
  - Issue to an r already busy and not returning that cycle: busy unchanged, ldr_err pulses next cycle.
  - Issue to PC index: ignored, ldr_err pulses.
- busy for the PC index is always 0. rd_busy[i] = busy[rd_addr[i]], unaffected by bypass (it reflects registered state).
- w_en1 to a busy register writes data but does not clear busy.
- PC, when load_pc=1:
  - sel_pc 01: start_pc
  - sel_pc 11: dp_pc
  - sel_pc 00/10: pc_out+1, modulo 2^PC_W (wraps all-ones to 0)
- load_pc=0: PC holds.

## Timing
- Reads, rd_busy and bypass are combinational; zero latency.
- Writes, busy, PC and ldr_err update on the rising clk edge; visible in stored form the next cycle.
- Reset (rst_n low, asynchronous, any time including mid-load):
  - all general registers 0, PC 0, busy_vec 0, ldr_err 0
  - hence rd_data 0 and rd_busy 0
  - outstanding loads are forgotten; a later w_en_ldr just writes.
- Release of rst_n is synchronised externally; first edge after release performs normal updates.

## Test plan
- Reset: drive rst_n low mid-run with busy_vec=0x0014, PC=0x123 -> immediately busy_vec=0, pc_out=0, all rd_data=0 without a clock edge.
- Dual write same address: w_en1 R3=0xAAAA_AAAA and w_en_ldr R3=0x5555_5555 with rd_addr[0]=3 -> rd_data[0]=0x5555_5555 same cycle (BYPASS=1); stored 0x5555_5555 next cycle. With BYPASS=0 the same-cycle read returns the old value.
- Scoreboard: issue R5 -> busy_vec[5]=1 and rd_busy=1 on the port reading 5. Same-cycle issue R5 plus return R5 -> busy stays 1. Issue R5 again with no return -> ldr_err=1 for exactly one cycle. Return R5=0x42 -> busy 0, R5=0x42.
- PC write protection: w_en1 to addr 15 with data 0xFFFF_FFFF -> PC unchanged; rd_addr=15 returns zero-extended pc_out.
- PC modes: start_pc=0x010 sel 01 -> 0x010; sel 00 three cycles -> 0x013; dp_pc=0x7FF sel 11 -> 0x7FF; sel 10 -> 0x000 wrap; load_pc=0 -> holds.
- Parametrisation: NUM_REGS=32, DATA_W=64, NUM_RD=6 -> all ports independently read and bypass; PC at index 31.
